// File: rtl/vga_line_timing.sv
// VGA line/frame timing generator with one-line-ahead prefetch requests to the cell line buffer.
// Define VGA_FRAME_CNT_EN to add the frame_cnt output and its 16-bit frame counter.
module vga_line_timing #(
  parameter int unsigned HActive = 640,
  parameter int unsigned HFront  = 16,
  parameter int unsigned HSync   = 96,
  parameter int unsigned HTotal  = 800,
  parameter int unsigned VActive = 480,
  parameter int unsigned VFront  = 10,
  parameter int unsigned VSync   = 2,
  parameter int unsigned VTotal  = 525
) (
  input  logic        Clk,
  input  logic        Reset_h,
  output logic        pix_ce,
  output logic        hs,
  output logic        vs,
  output logic        blank_n,
  output logic [9:0]  drawx,
  output logic [9:0]  drawy,
  output logic        line_req,
  output logic [8:0]  line_idx,
  input  logic        line_ack,
  output logic        underrun
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam logic [9:0] HAct       = 10'(HActive);
  localparam logic [9:0] HLast      = 10'(HTotal - 1);
  localparam logic [9:0] HSyncStart = 10'(HActive + HFront);
  localparam logic [9:0] HSyncEnd   = 10'(HActive + HFront + HSync - 1);
  localparam logic [9:0] VAct       = 10'(VActive);
  localparam logic [9:0] VReqLast   = 10'(VActive - 1);
  localparam logic [9:0] VLast      = 10'(VTotal - 1);
  localparam logic [9:0] VSyncStart = 10'(VActive + VFront);
  localparam logic [9:0] VSyncEnd   = 10'(VActive + VFront + VSync - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWaitLine} req_state_e;

  req_state_e state_q;
  logic       pix_ce_q, hs_q, vs_q, blank_n_q, line_req_q, underrun_q;
  logic [9:0] hc_q, hc_d, vc_q, vc_d;
  logic [8:0] line_idx_q;
  logic       line_end;

  // Last pixel clock of a line: the edge on which hc wraps and the request deadline falls.
  assign line_end = pix_ce_q && (hc_q == HLast);

  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (pix_ce_q) begin
      if (hc_q == HLast) begin
        hc_d = '0;
        vc_d = (vc_q == VLast) ? '0 : vc_q + 10'd1;
      end else begin
        hc_d = hc_q + 10'd1;
      end
    end
  end

  // Syncs and blanking come from the next-state counters so they line up with drawx/drawy.
  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      pix_ce_q  <= 1'b0;
      hc_q      <= '0;
      vc_q      <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
    end else begin
      pix_ce_q <= ~pix_ce_q;
      if (pix_ce_q) begin
        hc_q      <= hc_d;
        vc_q      <= vc_d;
        hs_q      <= !((hc_d >= HSyncStart) && (hc_d <= HSyncEnd));
        vs_q      <= !((vc_d >= VSyncStart) && (vc_d <= VSyncEnd));
        blank_n_q <= (hc_d < HAct) && (vc_d < VAct);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      state_q    <= StIdle;
      line_req_q <= 1'b0;
      line_idx_q <= '0;
      underrun_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pix_ce_q && (hc_q == HAct)) begin
            if (vc_q < VReqLast) begin
              state_q    <= StReq;
              line_req_q <= 1'b1;
              line_idx_q <= vc_q[8:0] + 9'd1;
            end else if (vc_q == VLast) begin
              state_q    <= StReq;
              line_req_q <= 1'b1;
              line_idx_q <= '0;
            end
          end
        end
        StReq: begin
          // An ack on the deadline edge still wins; the line has wrapped, so skip WAIT_LINE.
          if (line_ack) begin
            line_req_q <= 1'b0;
            state_q    <= line_end ? StIdle : StWaitLine;
          end else if (line_end) begin
            line_req_q <= 1'b0;
            underrun_q <= 1'b1;
            state_q    <= StIdle;
          end
        end
        StWaitLine: begin
          if (line_end) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      frame_cnt_q <= '0;
    end else if (line_end && (vc_q == VLast)) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign pix_ce   = pix_ce_q;
  assign hs       = hs_q;
  assign vs       = vs_q;
  assign blank_n  = blank_n_q;
  assign drawx    = hc_q;
  assign drawy    = vc_q;
  assign line_req = line_req_q;
  assign line_idx = line_idx_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_vga_line_timing.sv
// Scoreboard bench for vga_line_timing on a reduced raster; expected timing comes from
// pixel-index arithmetic, expected requests are queued by the model and popped on each req rise.
module tb_vga_line_timing;

  localparam int HA = 48;
  localparam int HF = 4;
  localparam int HSW = 8;
  localparam int HT = 64;
  localparam int VA = 10;
  localparam int VF = 2;
  localparam int VSW = 2;
  localparam int VT = 16;
  localparam int FramePx = HT * VT;

  logic       Clk = 1'b0;
  logic       Reset_h = 1'b1;
  logic       line_ack = 1'b0;
  logic       pix_ce, hs, vs, blank_n, line_req, underrun;
  logic [9:0] drawx, drawy;
  logic [8:0] line_idx;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  vga_line_timing #(
    .HActive(HA), .HFront(HF), .HSync(HSW), .HTotal(HT),
    .VActive(VA), .VFront(VF), .VSync(VSW), .VTotal(VT)
  ) dut (
    .Clk      (Clk),
    .Reset_h  (Reset_h),
    .pix_ce   (pix_ce),
    .hs       (hs),
    .vs       (vs),
    .blank_n  (blank_n),
    .drawx    (drawx),
    .drawy    (drawy),
    .line_req (line_req),
    .line_idx (line_idx),
    .line_ack (line_ack),
    .underrun (underrun)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt(frame_cnt)
`endif
  );

  always #10 Clk = ~Clk;

  int   checks = 0;
  int   failures = 0;
  int   c = 0;           // Clk cycles since the reset state appeared
  bit   model_ok = 0;
  bit   rst_prev = 0;
  bit   exp_underrun = 0;
  int   exp_q[$];
  bit   req_prev = 0;
  logic [8:0] idx_prev = '0;
  int   hs_low = 0, vs_lines = 0, blank_px = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got event, expected none (t=%0t)", name, $time);
  endtask

  function automatic int px_hc(input int cc);
    return (cc / 2) % HT;
  endfunction

  function automatic int px_vc(input int cc);
    return ((cc / 2) / HT) % VT;
  endfunction

  // Monitor: samples mid-cycle and compares against the pixel-index model.
  always @(negedge Clk) begin
    int n, h, v;
    logic [31:0] act_vec, exp_vec;
    if (rst_prev) begin
      c = 0;
      model_ok = 1;
      exp_q.delete();
      hs_low = 0;
      vs_lines = 0;
      blank_px = 0;
    end
    if (model_ok) begin
      n = c / 2;
      h = n % HT;
      v = (n / HT) % VT;
      exp_vec = {8'd0, 1'(c % 2), !(h >= HA + HF && h < HA + HF + HSW),
                 !(v >= VA + VF && v < VA + VF + VSW), (n != 0) && h < HA && v < VA,
                 10'(h), 10'(v)};
      act_vec = {8'd0, pix_ce, hs, vs, blank_n, drawx, drawy};
      check("timing", act_vec, exp_vec);
      check("underrun", 32'(underrun), 32'(exp_underrun));
      if (line_req && !req_prev) begin
        check("req_timing", h * 2 + c % 2, (HA + 1) * 2);
        if (exp_q.size() == 0) fail("req_unexpected");
        else check("req_idx", 32'(line_idx), exp_q.pop_front());
      end
      if (line_req && req_prev) check("idx_stable", 32'(line_idx), 32'(idx_prev));
      if (c % 2 == 1) begin
        if (h == HA && (v < VA - 1 || v == VT - 1)) begin
          if (exp_q.size() != 0) begin
            fail("req_missing");
            exp_q.delete();
          end
          exp_q.push_back(v == VT - 1 ? 0 : v + 1);
        end
        if (!hs) hs_low++;
        if (h == 0 && !vs) vs_lines++;
        if (blank_n) blank_px++;
        if (h == HT - 1) begin
          check("hs_low_px", hs_low, HSW);
          hs_low = 0;
          if (v == VT - 1) begin
            check("vs_low_lines", vs_lines, VSW);
            if (n >= FramePx) check("blank_px", blank_px, HA * VA);
            vs_lines = 0;
            blank_px = 0;
          end
        end
      end
    end
    req_prev = line_req;
    idx_prev = line_idx;
    rst_prev = Reset_h;
    c++;
  end

  task automatic wait_req(output bit ok);
    int guard = 0;
    ok = 1;
    while (!line_req) begin
      @(posedge Clk);
      #1;
      if (++guard > 2000) begin
        check("req_wait_timeout", 32'(line_req), 1);
        ok = 0;
        return;
      end
    end
  endtask

  task automatic wait_drop(input string name, input int limit);
    int guard = 0;
    while (line_req) begin
      @(posedge Clk);
      #1;
      if (++guard > limit) begin
        check(name, 32'(line_req), 0);
        return;
      end
    end
  endtask

  // Driver: acks each request, with directed deadline, underrun and reset-mid-request cases.
  initial begin
    bit ok;
    bit did_dl = 0, did_ur = 0, did_rst = 0;
    int vcur, guard;
    Reset_h = 1;
    repeat (3) @(posedge Clk);
    #1 Reset_h = 0;
    for (int k = 0; k < 60; k++) begin
      wait_req(ok);
      if (!ok) break;
      vcur = px_vc(c);
`ifdef VGA_FRAME_CNT_EN
      if (k == 30) check("frame_cnt_3", 32'(frame_cnt), 3);
`endif
      if (k >= 30 && !did_dl && vcur == 3) begin
        guard = 0;
        while (!(c % 2 == 1 && px_hc(c) == HT - 1) && guard < 100) begin
          @(posedge Clk);
          #1;
          guard++;
        end
        check("dl_still_req", 32'(line_req), 1);
        line_ack = 1;
        @(posedge Clk);
        #1;
        line_ack = 0;
        check("dl_req_drop", 32'(line_req), 0);
        check("dl_no_underrun", 32'(underrun), 0);
        did_dl = 1;
      end else if (did_dl && !did_ur && vcur == 5) begin
        wait_drop("ur_drop_timeout", 100);
        check("ur_drop_pos", px_hc(c) * 2 + c % 2, 0);
        check("ur_set", 32'(underrun), 1);
        exp_underrun = 1;
        did_ur = 1;
      end else if (did_ur && !did_rst && vcur == 7) begin
        Reset_h = 1;
        @(posedge Clk);
        #1;
        Reset_h = 0;
        exp_underrun = 0;
        check("rst_req", 32'(line_req), 0);
        check("rst_sync", {30'd0, hs, vs}, 3);
        check("rst_xy", {12'd0, drawx, drawy}, 0);
        check("rst_underrun", 32'(underrun), 0);
        did_rst = 1;
      end else begin
        repeat ((k < 30) ? 3 : $urandom_range(1, 12)) @(posedge Clk);
        #1 line_ack = 1;
        wait_drop("ack_drop_timeout", 50);
        line_ack = 0;
        if ($urandom_range(0, 1) == 1) begin
          line_ack = 1;
          repeat (2) @(posedge Clk);
          #1 line_ack = 0;
        end
      end
    end
    check("directed_done", {29'd0, did_dl, did_ur, did_rst}, 7);
    // Constant ack: every request completes on its first cycle.
    line_ack = 1;
`ifdef VGA_FRAME_CNT_EN
    force dut.frame_cnt_q = 16'hFFFF;
    @(posedge Clk);
    #1 release dut.frame_cnt_q;
    check("frame_cnt_preload", 32'(frame_cnt), 32'hFFFF);
    guard = 0;
    while (!(px_hc(c) == 0 && px_vc(c) == 0 && c % 2 == 0) && guard < 3000) begin
      @(posedge Clk);
      #1;
      guard++;
    end
    check("frame_cnt_wrap", 32'(frame_cnt), 0);
`endif
    repeat (600) @(posedge Clk);
    #1 line_ack = 0;
    repeat (4) @(posedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
